// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with per-frame snapshot.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits above digit 0.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    DisplayEn,
  input  logic [4*NUM_DIGITS-1:0] DigitsIn,
  input  logic [NUM_DIGITS-1:0]   DpMask,
  output logic [6:0]              Seg,
  output logic                    Dp,
  output logic [NUM_DIGITS-1:0]   Anode,
  output logic                    FrameTick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]   dpsnap_q, dpsnap_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    tick_q, tick_d;

  logic                    frame_start;
  logic                    wrap;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   lz;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [3:0]              cur;
  logic                    cur_dp;
  logic                    cur_lz;
  logic [6:0]              seg_act;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Slot timing, digit index and frame snapshot next-state.
  always_comb begin
    frame_start = (presc_q == '0) && (idx_q == '0);
    wrap        = (presc_q == PRE_LAST);
    presc_d     = wrap ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    snap_d   = frame_start ? DigitsIn : snap_q;
    dpsnap_d = frame_start ? DpMask : dpsnap_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic hz;

  // A digit is blank when it and every higher snapshot digit are zero.
  always_comb begin
    hz = 1'b1;
    lz = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hz    = hz && (snap_d[4*i +: 4] == 4'd0);
      lz[i] = hz;
    end
  end
`else
  assign lz = '0;
`endif

  // Output next-state; the frame-start slot already uses the new snapshot.
  always_comb begin
    cur    = '0;
    cur_dp = 1'b0;
    cur_lz = 1'b0;
    an_act = '0;
    lit    = DisplayEn && (int'(presc_q) >= BLANK_CYCLES);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur       = snap_d[4*i +: 4];
        cur_dp    = dpsnap_d[i];
        cur_lz    = lz[i];
        an_act[i] = lit;
      end
    end
    seg_act = cur_lz ? 7'h00 : decode(cur);
    seg_d   = seg_act ^ {7{POL}};
    dp_d    = cur_dp ^ POL;
    anode_d = an_act ^ {NUM_DIGITS{POL}};
    tick_d  = frame_start;
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
      dpsnap_q <= '0;
      seg_q    <= {7{POL}};
      dp_q     <= POL;
      anode_q  <= {NUM_DIGITS{POL}};
      tick_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      dpsnap_q <= dpsnap_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      anode_q  <= anode_d;
      tick_q   <= tick_d;
    end
  end

  assign Seg       = seg_q;
  assign Dp        = dp_q;
  assign Anode     = anode_q;
  assign FrameTick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver.
// Small config: SCAN_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=3.
module tb_seven_seg_scan_driver;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        DisplayEn;
  logic [11:0] DigitsIn;
  logic [2:0]  DpMask;
  logic [6:0]  Seg;
  logic        Dp;
  logic [2:0]  Anode;
  logic        FrameTick;

  int checks = 0;
  int fails  = 0;

  always #5 Clk = ~Clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS  (3),
    .SCAN_DIV    (4),
    .BLANK_CYCLES(1),
    .ACTIVE_LOW  (1)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .DisplayEn(DisplayEn),
    .DigitsIn (DigitsIn),
    .DpMask   (DpMask),
    .Seg      (Seg),
    .Dp       (Dp),
    .Anode    (Anode),
    .FrameTick(FrameTick)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    step();
    while (FrameTick !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (FrameTick !== 1'b1) begin
      fails++;
      $display("FAIL wait_tick: FrameTick=%b required 1", FrameTick);
    end
  endtask

  task automatic test_reset();
    int n;
    Reset     = 1'b1;
    DisplayEn = 1'b1;
    DigitsIn  = 12'h125;
    DpMask    = 3'b000;
    step();
    step();
    checks += 4;
    if (Anode !== 3'b111) begin
      fails++;
      $display("FAIL rst_anode: got %b want 111", Anode);
    end
    if (Seg !== 7'h7F) begin
      fails++;
      $display("FAIL rst_seg: got %b want 1111111", Seg);
    end
    if (Dp !== 1'b1) begin
      fails++;
      $display("FAIL rst_dp: got %b want 1", Dp);
    end
    if (FrameTick !== 1'b0) begin
      fails++;
      $display("FAIL rst_tick: got %b want 0", FrameTick);
    end
    Reset = 1'b0;
    step();
    checks++;
    if (FrameTick !== 1'b1) begin
      fails++;
      $display("FAIL first_tick: got %b want 1", FrameTick);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (FrameTick !== 1'b1 && n < 30);
      checks++;
      if (n != 12) begin
        fails++;
        $display("FAIL tick_period%0d: got %0d want 12", k, n);
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] es [3];
    logic [2:0] an [3];
    logic [2:0] ea;
    es[0] = 7'b0010010;
    es[1] = 7'b0100100;
    es[2] = 7'b1111001;
    an[0] = 3'b110;
    an[1] = 3'b101;
    an[2] = 3'b011;
    wait_tick();
    for (int p = 0; p < 12; p++) begin
      if (p > 0) step();
      ea = (p % 4 == 0) ? 3'b111 : an[p / 4];
      checks += 4;
      if (Anode !== ea) begin
        fails++;
        $display("FAIL scan_anode p=%0d: got %b want %b", p, Anode, ea);
      end
      if (Seg !== es[p / 4]) begin
        fails++;
        $display("FAIL scan_seg p=%0d: got %b want %b", p, Seg, es[p / 4]);
      end
      if (Dp !== 1'b1) begin
        fails++;
        $display("FAIL scan_dp p=%0d: got %b want 1", p, Dp);
      end
      if (FrameTick !== (p == 0)) begin
        fails++;
        $display("FAIL scan_tick p=%0d: got %b", p, FrameTick);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] eo [3];
    logic [6:0] en [3];
    logic [6:0] e;
    eo[0] = 7'b0010010;
    eo[1] = 7'b0100100;
    eo[2] = 7'b1111001;
    en[0] = 7'b1111000;
`ifdef LEADING_ZERO_BLANK_EN
    en[1] = 7'h7F;
    en[2] = 7'h7F;
`else
    en[1] = 7'b1000000;
    en[2] = 7'b1000000;
`endif
    wait_tick();
    for (int p = 0; p < 24; p++) begin
      if (p > 0) step();
      e = (p < 12) ? eo[(p % 12) / 4] : en[(p % 12) / 4];
      checks++;
      if (Seg !== e) begin
        fails++;
        $display("FAIL snap_seg p=%0d: got %b want %b", p, Seg, e);
      end
      if (p == 5) DigitsIn = 12'h007;
    end
  endtask

  task automatic test_dash_dp();
    logic [6:0] es [3];
    logic       ed;
    es[0] = 7'b0010010;
    es[1] = 7'b0111111;
    es[2] = 7'b1111001;
    wait_tick();
    DigitsIn = 12'h1C5;
    DpMask   = 3'b010;
    wait_tick();
    for (int p = 0; p < 12; p++) begin
      if (p > 0) step();
      ed = (p / 4 == 1) ? 1'b0 : 1'b1;
      checks += 2;
      if (Seg !== es[p / 4]) begin
        fails++;
        $display("FAIL dash_seg p=%0d: got %b want %b", p, Seg, es[p / 4]);
      end
      if (Dp !== ed) begin
        fails++;
        $display("FAIL dash_dp p=%0d: got %b want %b", p, Dp, ed);
      end
    end
  endtask

  task automatic test_display_en();
    wait_tick();
    DisplayEn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks += 2;
      if (Anode !== 3'b111) begin
        fails++;
        $display("FAIL den_anode k=%0d: got %b want 111", k, Anode);
      end
      if (FrameTick !== 1'b0) begin
        fails++;
        $display("FAIL den_tick k=%0d: got %b want 0", k, FrameTick);
      end
    end
    DisplayEn = 1'b1;
    step();
    checks++;
    if (Anode !== 3'b011) begin
      fails++;
      $display("FAIL den_resume: got %b want 011", Anode);
    end
    step();
    step();
    step();
    checks++;
    if (FrameTick !== 1'b1) begin
      fails++;
      $display("FAIL den_period: got %b want 1", FrameTick);
    end
  endtask

  task automatic test_reset_mid();
    wait_tick();
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (Anode !== 3'b101) begin
      fails++;
      $display("FAIL mid_pre_anode: got %b want 101", Anode);
    end
    Reset    = 1'b1;
    DigitsIn = 12'h048;
    step();
    checks += 4;
    if (Anode !== 3'b111) begin
      fails++;
      $display("FAIL mid_rst_anode: got %b want 111", Anode);
    end
    if (Seg !== 7'h7F) begin
      fails++;
      $display("FAIL mid_rst_seg: got %b want 1111111", Seg);
    end
    if (Dp !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst_dp: got %b want 1", Dp);
    end
    if (FrameTick !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_tick: got %b want 0", FrameTick);
    end
    Reset = 1'b0;
    step();
    checks += 3;
    if (FrameTick !== 1'b1) begin
      fails++;
      $display("FAIL mid_tick: got %b want 1", FrameTick);
    end
    if (Seg !== 7'b0000000) begin
      fails++;
      $display("FAIL mid_seg0: got %b want 0000000", Seg);
    end
    if (Anode !== 3'b111) begin
      fails++;
      $display("FAIL mid_blank0: got %b want 111", Anode);
    end
    step();
    checks++;
    if (Anode !== 3'b110) begin
      fails++;
      $display("FAIL mid_anode0: got %b want 110", Anode);
    end
    for (int k = 0; k < 4; k++) step();
    checks += 3;
    if (Anode !== 3'b101) begin
      fails++;
      $display("FAIL mid_anode1: got %b want 101", Anode);
    end
    if (Seg !== 7'b0011001) begin
      fails++;
      $display("FAIL mid_seg1: got %b want 0011001", Seg);
    end
    if (Dp !== 1'b0) begin
      fails++;
      $display("FAIL mid_dp1: got %b want 0", Dp);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_dash_dp();
    test_display_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
